// File: rtl/pair_chk_pkg.sv
// rtl/pair_chk_pkg.sv - shared state encoding, error codes and parameter defaults
package pair_chk_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MISMATCH  = 2'b01;
    localparam logic [1:0] ERR_INVARIANT = 2'b10;
    localparam logic [1:0] ERR_FORBIDDEN = 2'b11;

    localparam int W_DEF      = 8;
    localparam int X_INIT_DEF = 2;
    localparam int Y_INIT_DEF = 0;
    localparam int X_STEP_DEF = 2;
    localparam int Y_STEP_DEF = 1;

    localparam logic [7:0] VIOL_MAX = 8'hFF;

endpackage

// File: rtl/pair_step_checker_if.sv
// rtl/pair_step_checker_if.sv - pair sample inputs and error report outputs
interface pair_step_checker_if
    import pair_chk_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         step_in;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic         err_ack;
    logic         err_valid;
    logic [1:0]   err_code;
    logic [W-1:0] err_x;
    logic [W-1:0] err_y;
    logic [7:0]   viol_cnt;
    logic [15:0]  step_cnt;
    logic [1:0]   state_o;

    modport master (
        output step_in, x_in, y_in, err_ack,
        input  err_valid, err_code, err_x, err_y, viol_cnt, step_cnt, state_o
    );

    modport slave (
        input  step_in, x_in, y_in, err_ack,
        output err_valid, err_code, err_x, err_y, viol_cnt, step_cnt, state_o
    );
endinterface

// File: rtl/pair_model.sv
// rtl/pair_model.sv - expected (x, y) tracker mirroring the upstream counter stage
module pair_model
    import pair_chk_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int X_INIT = X_INIT_DEF,
    parameter int Y_INIT = Y_INIT_DEF,
    parameter int X_STEP = X_STEP_DEF,
    parameter int Y_STEP = Y_STEP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         enable,
    output logic [W-1:0] exp_x,
    output logic [W-1:0] exp_y
);
    localparam logic [W-1:0] XI = W'(X_INIT);
    localparam logic [W-1:0] YI = W'(Y_INIT);
    localparam logic [W-1:0] XS = W'(X_STEP);
    localparam logic [W-1:0] YS = W'(Y_STEP);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            exp_x <= XI;
            exp_y <= YI;
        end else if (enable && step) begin
            exp_x <= exp_x + XS;
            exp_y <= exp_y + YS;
        end
    end
endmodule

// File: rtl/pair_step_checker.sv
// rtl/pair_step_checker.sv - checks a stepped (x, y) counter pair against a model and invariant
module pair_step_checker
    import pair_chk_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int X_INIT = X_INIT_DEF,
    parameter int Y_INIT = Y_INIT_DEF,
    parameter int X_STEP = X_STEP_DEF,
    parameter int Y_STEP = Y_STEP_DEF
) (
    input logic                 clk,
    input logic                 rst,
    pair_step_checker_if.slave  bus
);
    localparam logic [W-1:0] XI = W'(X_INIT);
    localparam logic [W-1:0] YI = W'(Y_INIT);
    localparam logic [W-1:0] XS = W'(X_STEP);
    localparam logic [W-1:0] X_FORBID = W'(4);

    state_t       state, state_nx;
    logic         load;
    logic         detect;
    logic [1:0]   code_nx;
    logic [W-1:0] exp_x, exp_y;
    logic [W-1:0] inv_x;

    // x implied by y on the legal line, wrapping at the datapath width
    assign inv_x = XS * bus.y_in + XI;

    always_comb begin
        code_nx = ERR_NONE;
        if (bus.y_in == '0 && bus.x_in == X_FORBID)
            code_nx = ERR_FORBIDDEN;
        else if (bus.x_in != inv_x)
            code_nx = ERR_INVARIANT;
        else if (bus.x_in != exp_x || bus.y_in != exp_y)
            code_nx = ERR_MISMATCH;
    end

    assign detect = (state == ST_TRACK) && (code_nx != ERR_NONE);

    pair_model #(
        .W      (W),
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT),
        .X_STEP (X_STEP),
        .Y_STEP (Y_STEP)
    ) u_model (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (bus.step_in),
        .enable (state == ST_TRACK && !detect),
        .exp_x  (exp_x),
        .exp_y  (exp_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_SYNC;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (bus.x_in == XI && bus.y_in == YI) begin
                    state_nx = ST_TRACK;
                    load     = 1'b1;
                end
            end
            ST_TRACK: begin
                if (detect) state_nx = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.err_ack) state_nx = ST_SYNC;
            end
            default: state_nx = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err_valid <= 1'b0;
            bus.err_code  <= ERR_NONE;
            bus.err_x     <= '0;
            bus.err_y     <= '0;
            bus.viol_cnt  <= '0;
            bus.step_cnt  <= '0;
        end else begin
            if (state == ST_TRACK && bus.step_in)
                bus.step_cnt <= bus.step_cnt + 16'd1;
            if (detect) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= code_nx;
                bus.err_x     <= bus.x_in;
                bus.err_y     <= bus.y_in;
                if (bus.viol_cnt != VIOL_MAX)
                    bus.viol_cnt <= bus.viol_cnt + 8'd1;
            end
            if (state == ST_FAULT && bus.err_ack)
                bus.err_valid <= 1'b0;
        end
    end

    assign bus.state_o = state;
endmodule

// File: doc/pair_step_checker.md
PAIR_STEP_CHECKER -- requirements
Module: pair_step_checker

Interface
REQ-001 SHALL have parameter W, default 8, the pair datapath width.
REQ-002 SHALL have parameter X_INIT, default 2, the expected x after producer reset.
REQ-003 SHALL have parameter Y_INIT, default 0, the expected y after producer reset.
REQ-004 SHALL have parameter X_STEP, default 2, the x increment per step.
REQ-005 SHALL have parameter Y_STEP, default 1, the y increment per step.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port step_in, input, 1, the selector driven to the upstream x/y counter stage.
REQ-009 SHALL have ports x_in and y_in, input, W each, the registered pair from the counter stage.
REQ-010 SHALL have port err_ack, input, 1, the consumer acknowledge of a reported error.
REQ-011 SHALL have port err_valid, output, 1, error report pending.
REQ-012 SHALL have port err_code, output, 2; 01 = model mismatch, 10 = invariant violation, 11 = forbidden pair.
REQ-013 SHALL have ports err_x and err_y, output, W each, the captured offending pair.
REQ-014 SHALL have port viol_cnt, output, 8, the number of errors reported.
REQ-015 SHALL have port step_cnt, output, 16, the number of steps observed in TRACK.
REQ-016 SHALL have port state_o, output, 2; SYNC = 00, TRACK = 01, FAULT = 10.

Function
REQ-017 SHALL implement FSM SYNC/TRACK/FAULT.
- SYNC -> TRACK: the sampled pair equals (X_INIT, Y_INIT); load exp_x = X_INIT, exp_y = Y_INIT.
REQ-018 SHALL, in TRACK, check the sampled pair each cycle, modulo 2^W, with priority forbidden > invariant > mismatch:
- forbidden: y_in == 0 and x_in == 4;
- invariant: x_in != (X_STEP*y_in + X_INIT) mod 2^W;
- mismatch: (x_in, y_in) != (exp_x, exp_y).
REQ-019 SHALL, in TRACK with no error, update the model: exp_x += step_in ? X_STEP : 0 and exp_y += step_in ? Y_STEP : 0, wrapping mod 2^W; a step taken in cycle n is checked against the sample in cycle n+1.
REQ-020 SHALL, when an error is detected in cycle n, enter FAULT in cycle n+1 with err_valid = 1, err_code set, and err_x/err_y holding the cycle-n sample.
REQ-021 SHALL increment viol_cnt once per entry into FAULT, saturating at 255.
REQ-022 SHALL hold err_valid and the captured fields stable in FAULT until err_ack = 1, then clear err_valid and go to SYNC on the next cycle.
REQ-023 SHALL ignore err_ack outside FAULT.
REQ-024 SHALL ignore inputs in FAULT; no further checks or counts are made there.
REQ-025 SHALL increment step_cnt on every TRACK cycle with step_in = 1, wrapping at 2^16.
REQ-026 SHALL treat y wrap 255 -> 0 with x 0 -> 2 as legal; no error.

Reset
REQ-027 SHALL, on rst, set state SYNC, err_valid 0, err_code 00, err_x/err_y 0, viol_cnt 0, step_cnt 0, exp_x X_INIT, exp_y Y_INIT.
REQ-028 SHALL give rst priority over err_ack and over any error detected in the same cycle.
REQ-029 SHALL, on rst asserted mid-TRACK or mid-FAULT, take reset values on the next edge, discarding any pending report.

Structure
REQ-030 SHALL place the state encoding, err_code constants and parameter defaults in package pair_chk_pkg.
REQ-031 SHALL implement the exp_x/exp_y tracker as sub-module pair_model (inputs: load, step, enable; outputs: exp_x, exp_y).

Verification
REQ-032 Reset then step_in = 1 for 3 cycles -> TRACK; pairs (2,0),(4,1),(6,2),(8,3) accepted; step_cnt = 3; err_valid = 0.
REQ-033 300 consecutive steps -> y wraps 255 -> 0 with x = 2; no error; step_cnt = 300.
REQ-034 Force pair (4,0) in TRACK -> next cycle err_valid = 1, err_code = 11, err_x = 4, err_y = 0, viol_cnt = 1.
REQ-035 Force pair (10,3) where (8,3) is expected -> err_code = 10; err_ack pulse -> SYNC; resync on (2,0) -> TRACK.
REQ-036 Hold step_in = 0 while the pair advances to (4,1) -> err_code = 01.
REQ-037 Assert rst in the same cycle as err_ack while in FAULT -> all outputs at reset values; viol_cnt = 0.
